// File: rtl/alu_pkg.sv
// Shared opcode map, response entry type and FSM state type for the ALU sequencer.
// Ports: none (package only).
// Imported by alu_sequencer and its response FIFO.
package alu_pkg;

  localparam int ALU_RW = 9;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_ROL  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_XNOR = 4'b1100;
  localparam logic [3:0] OP_LT   = 4'b1101;
  localparam logic [3:0] OP_GT   = 4'b1110;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  typedef enum logic {
    ST_IDLE,
    ST_EXEC
  } state_t;

  typedef struct packed {
    logic              err;
    logic [ALU_RW-1:0] data;
  } rsp_t;

  // Opcodes 0010 and 0111 have no ALU function behind them.
  function automatic logic is_reserved(input logic [3:0] sel);
    return (sel == 4'b0010) || (sel == 4'b0111);
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Show-ahead response FIFO: head comes straight from registered storage.
// Latency: a push at edge N is visible at the head after N when the FIFO was empty.
// Ports: push/push_data write, pop advances the head, count is occupancy 0..DEPTH.
module alu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             AW   = $clog2(DEPTH);
  localparam logic [AW:0]    FULL = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pop is ignored when empty; a push into a full FIFO is only taken
  // when a pop frees a slot in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/alu_sequencer.sv
// Command-issue / response-buffer stage around the combinational 8-bit ALU.
// Latency: accept at edge N drives the ALU after N, result queued at N+1; one command per 2 cycles.
// Backpressure: cmd_ready only in IDLE with a free FIFO slot; rsp_* held while rsp_valid && !rsp_ready.
// Ports: cmd_* in (valid/ready), alu_a/b/sel out + alu_result in, rsp_* out (valid/ready), acc, busy.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_a,
  input  logic [7:0]        cmd_b,
  input  logic [3:0]        cmd_sel,
  input  logic              cmd_use_acc,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [3:0]        alu_sel,
  input  logic [ALU_RW-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ALU_RW-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic              rsp_err,
  output logic [7:0]        acc,
  output logic              busy
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;

  state_t          state;
  logic [CW-1:0]   count;
  rsp_t            push_entry;
  rsp_t            head;
  logic            push;
  logic            pop;

  // Free slot is checked at accept time, so the EXEC push can never overflow.
  assign cmd_ready = (state == ST_IDLE) && (count < CW'(RSP_DEPTH));
  assign busy      = (state == ST_EXEC);
  assign push      = (state == ST_EXEC);
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;

  // Divide-by-zero and reserved opcodes replace the ALU output with a zero error entry.
  always_comb begin
    push_entry.err  = 1'b0;
    push_entry.data = alu_result;
    if (((alu_sel == OP_DIV) && (alu_b == 8'h00)) || is_reserved(alu_sel)) begin
      push_entry.err  = 1'b1;
      push_entry.data = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      acc     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            alu_a   <= cmd_use_acc ? acc : cmd_a;
            alu_b   <= cmd_b;
            alu_sel <= cmd_sel;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // acc moves on the push edge so a use_acc command in the next IDLE cycle sees it.
          if (!push_entry.err) acc <= push_entry.data[7:0];
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  alu_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     ($bits(rsp_t))
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign rsp_data  = head.data;
  assign rsp_err   = head.err;
  assign rsp_carry = head.data[ALU_RW-1];
  assign rsp_zero  = (head.data == '0) && !head.err;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_sel;
  logic       cmd_use_acc;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [8:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [8:0] rsp_data;
  logic       rsp_zero;
  logic       rsp_carry;
  logic       rsp_err;
  logic [7:0] acc;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  alu_sequencer #(.RSP_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_sel     (cmd_sel),
    .cmd_use_acc (cmd_use_acc),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_result  (alu_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_zero    (rsp_zero),
    .rsp_carry   (rsp_carry),
    .rsp_err     (rsp_err),
    .acc         (acc),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Simple combinational ALU for the opcodes exercised here; unknown opcodes
  // return a non-zero pattern so forced-zero error entries are visible.
  always_comb begin
    alu_result = 9'h1AA;
    case (alu_sel)
      4'b0000: alu_result = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0001: alu_result = {1'b0, alu_a} - {1'b0, alu_b};
      4'b0011: alu_result = (alu_b != 8'h00) ? {1'b0, alu_a / alu_b} : 9'h1AA;
      4'b0101: alu_result = {1'b0, alu_a >> 1};
      4'b1000: alu_result = {1'b0, alu_a & alu_b};
      default: alu_result = 9'h1AA;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) for cmd_ready, then step through the accept edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] sel, input logic use_acc);
    cmd_valid   = 1'b1;
    cmd_a       = a;
    cmd_b       = b;
    cmd_sel     = sel;
    cmd_use_acc = use_acc;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    if (!cmd_ready) check("issue_timeout", 32'(cmd_ready), 32'(1));
    tick();
    cmd_valid   = 1'b0;
    cmd_use_acc = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_a       = '0;
    cmd_b       = '0;
    cmd_sel     = '0;
    cmd_use_acc = 1'b0;
    rsp_ready   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("rst_alu_a",     32'(alu_a),     32'(0));
    check("rst_alu_b",     32'(alu_b),     32'(0));
    check("rst_alu_sel",   32'(alu_sel),   32'(0));
    check("rst_acc",       32'(acc),       32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_err",   32'(rsp_err),   32'(0));
    check("rst_rsp_carry", 32'(rsp_carry), 32'(0));
    check("rst_rsp_data",  32'(rsp_data),  32'(0));
    check("rst_busy",      32'(busy),      32'(0));

    // ADD with carry: FF + 01 = 100
    rsp_ready = 1'b1;
    issue(8'hFF, 8'h01, 4'b0000, 1'b0);
    check("add_alu_a",     32'(alu_a),     32'hFF);
    check("add_busy",      32'(busy),      32'(1));
    check("add_cmd_ready", 32'(cmd_ready), 32'(0));
    tick();
    check("add_valid", 32'(rsp_valid), 32'(1));
    check("add_data",  32'(rsp_data),  32'h100);
    check("add_carry", 32'(rsp_carry), 32'(1));
    check("add_zero",  32'(rsp_zero),  32'(0));
    check("add_acc",   32'(acc),       32'h00);

    // SUB borrow: 5 - 7 = 1FE, then SHR of the accumulator
    issue(8'h05, 8'h07, 4'b0001, 1'b0);
    tick();
    check("sub_data",  32'(rsp_data),  32'h1FE);
    check("sub_carry", 32'(rsp_carry), 32'(1));
    check("sub_acc",   32'(acc),       32'hFE);
    issue(8'h33, 8'h00, 4'b0101, 1'b1);
    check("shr_alu_a", 32'(alu_a), 32'hFE);
    tick();
    check("shr_data",  32'(rsp_data),  32'h07F);
    check("shr_carry", 32'(rsp_carry), 32'(0));
    check("shr_acc",   32'(acc),       32'h7F);

    // Divide by zero, reserved opcode, then a good divide
    issue(8'h09, 8'h00, 4'b0011, 1'b0);
    tick();
    check("div0_err",  32'(rsp_err),  32'(1));
    check("div0_data", 32'(rsp_data), 32'(0));
    check("div0_zero", 32'(rsp_zero), 32'(0));
    check("div0_acc",  32'(acc),      32'h7F);
    issue(8'h01, 8'h02, 4'b0111, 1'b0);
    tick();
    check("rsv_err",  32'(rsp_err),  32'(1));
    check("rsv_data", 32'(rsp_data), 32'(0));
    check("rsv_acc",  32'(acc),      32'h7F);
    issue(8'h09, 8'h03, 4'b0011, 1'b0);
    tick();
    check("div_err",  32'(rsp_err),  32'(0));
    check("div_data", 32'(rsp_data), 32'h003);
    check("div_acc",  32'(acc),      32'h03);
    tick();
    check("drained", 32'(rsp_valid), 32'(0));

    // Backpressure: fill four entries 11..14
    rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      issue(8'(i), 8'h10, 4'b0000, 1'b0);
      tick();
    end
    check("bp_full_ready", 32'(cmd_ready), 32'(0));
    check("bp_full_head",  32'(rsp_data),  32'h011);
    cmd_valid = 1'b1;
    cmd_a     = 8'h05;
    cmd_b     = 8'h10;
    cmd_sel   = 4'b0000;
    tick();
    tick();
    check("bp_held_busy",  32'(busy),      32'(0));
    check("bp_held_ready", 32'(cmd_ready), 32'(0));
    check("bp_held_head",  32'(rsp_data),  32'h011);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_pop_ready", 32'(cmd_ready), 32'(1));
    check("bp_pop_head",  32'(rsp_data),  32'h012);
    tick();
    cmd_valid = 1'b0;
    check("bp_5th_busy", 32'(busy),  32'(1));
    check("bp_5th_alua", 32'(alu_a), 32'h05);
    tick();
    check("bp_refull_ready", 32'(cmd_ready), 32'(0));

    // Drain while a 6th command enters: push and pop coincide on its EXEC edge
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_a     = 8'h06;
    tick();
    check("pp_head_13", 32'(rsp_data), 32'h013);
    tick();
    cmd_valid = 1'b0;
    check("pp_head_14", 32'(rsp_data), 32'h014);
    check("pp_busy",    32'(busy),     32'(1));
    tick();
    check("pp_head_15", 32'(rsp_data), 32'h015);
    tick();
    check("pp_head_16", 32'(rsp_data), 32'h016);
    tick();
    check("pp_empty", 32'(rsp_valid), 32'(0));

    // Continuous stream with the consumer always ready: never more than one entry
    for (int i = 0; i < 5; i++) begin
      issue(8'(i * 16 + 1), 8'h02, 4'b0000, 1'b0);
      check("st_empty_on_accept", 32'(rsp_valid), 32'(0));
      tick();
      check("st_valid", 32'(rsp_valid), 32'(1));
      check("st_data",  32'(rsp_data),  32'(i * 16 + 3));
      check("st_ready", 32'(cmd_ready), 32'(1));
    end

    // Reset during EXEC with two entries queued
    rsp_ready = 1'b0;
    tick();
    issue(8'h20, 8'h01, 4'b0000, 1'b0);
    tick();
    issue(8'h30, 8'h02, 4'b0000, 1'b0);
    tick();
    issue(8'h40, 8'h03, 4'b0000, 1'b0);
    check("mid_busy", 32'(busy), 32'(1));
    check("mid_acc",  32'(acc),  32'h32);
    rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(rsp_valid), 32'(0));
    check("mr_busy",  32'(busy),      32'(0));
    check("mr_acc",   32'(acc),       32'(0));
    check("mr_alu_a", 32'(alu_a),     32'(0));
    tick();
    rst_n = 1'b1;
    #1;
    check("mr_cmd_ready", 32'(cmd_ready), 32'(1));
    check("mr_valid_rel", 32'(rsp_valid), 32'(0));
    issue(8'h01, 8'h01, 4'b0000, 1'b0);
    tick();
    check("post_rst_data", 32'(rsp_data), 32'h002);
    check("post_rst_acc",  32'(acc),      32'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-issue and response-buffer stage wrapped around the combinational 8-bit ALU. It accepts operand/opcode commands over a valid/ready handshake and registers them onto the ALU inputs. One cycle later it samples the 9-bit ALU result, derives flags, updates an accumulator, and queues the result in a response FIFO for the downstream consumer. It sits between the instruction/operand source and the result consumer, and is the only block that drives the ALU's inputs.

## Interface

**Parameters**
- `RSP_DEPTH`, default 4: response FIFO entries; power of two, ≥ 2.

**Ports**
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_a` in 8: operand A.
- `cmd_b` in 8: operand B.
- `cmd_sel` in 4: ALU opcode.
- `cmd_use_acc` in 1: when 1, A is taken from the accumulator and `cmd_a` is ignored.
- `alu_a` out 8: registered operand A to the ALU.
- `alu_b` out 8: registered operand B to the ALU.
- `alu_sel` out 4: registered opcode to the ALU.
- `alu_result` in 9: combinational ALU result.
- `rsp_valid` out 1: FIFO head valid.
- `rsp_ready` in 1: consumer pops when `rsp_valid && rsp_ready`.
- `rsp_data` out 9: result at the FIFO head.
- `rsp_zero` out 1: head `rsp_data == 9'h000` and `rsp_err == 0`.
- `rsp_carry` out 1: head `rsp_data[8]`.
- `rsp_err` out 1: head result invalid (divide by zero or reserved opcode).
- `acc` out 8: accumulator value.
- `busy` out 1: FSM not in IDLE.

## Operation

**FSM states:** IDLE, EXEC.
- **IDLE:** `cmd_ready = (count < RSP_DEPTH)`. On handshake, capture the operands:
  - `alu_a <= cmd_use_acc ? acc : cmd_a`
  - `alu_b <= cmd_b`
  - `alu_sel <= cmd_sel`
  - Go to EXEC.
- **EXEC:** `cmd_ready = 0`. Sample `alu_result`, push one entry `{err, data}`, return to IDLE. The push never overflows, because the free slot was checked at accept time.

**Error rules, applied in EXEC:**
- `alu_sel == 4'b0011` and `alu_b == 0`: `err = 1`, `data = 9'h000`.
- `alu_sel` in {`4'b0010`, `4'b0111`} (reserved): `err = 1`, `data = 9'h000`.
- Otherwise: `err = 0`, `data = alu_result`.

**Accumulator:**
- On a push with `err = 0`: `acc <= data[7:0]`.
- On `err = 1`: `acc` is unchanged.

**Arithmetic and width rules:**
- No width manipulation is done on `alu_result`; all 9 bits are stored.
- Subtraction borrow therefore appears as bit 8. Example: 5 − 7 = 9'h1FE, so `rsp_carry = 1`.

**FIFO:**
- Show-ahead: head outputs come from registered storage.
- Pointers wrap modulo `RSP_DEPTH`; occupancy is held in `count` (0..`RSP_DEPTH`).
- Simultaneous push and pop: `count` unchanged, data order preserved.
- Pop on empty cannot occur, because `rsp_valid = (count != 0)`.

**Reset (asserted at any time, including in EXEC):**
- Command in flight is dropped.
- FIFO is flushed.
- State returns to IDLE.

## Timing

**Reset values:**
- `cmd_ready` = 1 (after release, FIFO empty).
- `alu_a`, `alu_b`, `alu_sel`, `acc` = 0.
- `rsp_valid`, `rsp_err`, `rsp_carry` = 0; `rsp_data` = 0.
- `busy` = 0.

**Latency and throughput:**
- Command accepted at edge N → ALU inputs valid after N.
- Result pushed at edge N+1 → `rsp_valid` high after N+1 if the FIFO was empty.
- Throughput: one command per 2 cycles.

**Backpressure:**
- `cmd_ready` depends only on registered state and `count`; there is no combinational path from `cmd_valid` or `rsp_ready`.
- A pop at edge M with the FIFO full raises `cmd_ready` after M.

**Handshake rules:**
- `cmd_*` must be held stable while `cmd_valid && !cmd_ready`.
- `rsp_*` are held stable while `rsp_valid && !rsp_ready`.

**Accumulator timing:**
- `acc` updates at the same edge as the push.
- A `cmd_use_acc` command accepted in the IDLE cycle immediately following sees the updated `acc`.

## Structure

**Shared package `alu_pkg`:**
- Opcode localparams: `OP_ADD` = 0000, `OP_SUB` = 0001, `OP_DIV` = 0011, `OP_SHL` = 0100, `OP_SHR` = 0101, `OP_ROL` = 0110, `OP_AND` = 1000 … `OP_EQ` = 1111.
- Reserved-opcode check function.
- Result width constant `ALU_RW = 9`.
- Response entry typedef `{err, data[8:0]}`.

**Sub-module `alu_rsp_fifo`:**
- Parameterised depth and entry width.
- Push/pop, count, show-ahead head.

**Top level:** FSM, operand registers, error logic, accumulator.

## Test plan

- **ADD with carry:** A=8'hFF, B=8'h01, sel=0000, `rsp_ready=1` → after 2 edges `rsp_data=9'h100`, `rsp_carry=1`, `rsp_zero=0`, `acc=8'h00`.
- **SUB borrow and accumulator chain:** A=5, B=7, sel=0001 → `rsp_data=9'h1FE`. Then `cmd_use_acc=1`, sel=0101 → `alu_a=8'hFE`, `rsp_data=9'h07F`.
- **Divide by zero and reserved opcode:**
  - A=9, B=0, sel=0011 → `rsp_err=1`, `rsp_data=0`, `rsp_zero=0`, `acc` unchanged.
  - sel=0111 → `rsp_err=1`.
- **Backpressure:** `rsp_ready=0`, issue 5 commands back-to-back → 4 accepted, `cmd_ready=0` with `count=4`. Pulse `rsp_ready` one cycle → `cmd_ready=1` next cycle, 5th accepted, FIFO order preserved.
- **Simultaneous push/pop:** `rsp_ready=1` with a continuous command stream → `count` stays at most 1, every result delivered in order.
- **Reset mid-operation:** assert `rsp_n` low during EXEC with 2 entries queued → immediately `rsp_valid=0`, `busy=0`, `acc=0`. After release, `cmd_ready=1`.
